// File: rtl/decode_cycle.sv
// decode_cycle: RV32I decode stage. Decodes InstrD into execute-stage
// controls, reads the register file (write port driven from writeback, with
// write-through bypass) and sign-extends the immediate. Everything lands in
// the ID/EX register.
//   in : clk, rst (async, active low), InstrD, PCD, PCPlus4D,
//        RegWriteW/RDW/ResultW (register write port), FlushE (bubble into ID/EX)
//   out: RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE,
//        RD1_E, RD2_E, Imm_Ext_E, RD_E, RS1_E, RS2_E, PCE, PCPlus4E
module decode_cycle #(
  parameter int XLEN      = 32,
  parameter int REG_COUNT = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     InstrD,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic            RegWriteW,
  input  logic [4:0]      RDW,
  input  logic [XLEN-1:0] ResultW,
  input  logic            FlushE,
  output logic            RegWriteE,
  output logic            ALUSrcE,
  output logic            MemWriteE,
  output logic            ResultSrcE,
  output logic            BranchE,
  output logic [2:0]      ALUControlE,
  output logic [XLEN-1:0] RD1_E,
  output logic [XLEN-1:0] RD2_E,
  output logic [XLEN-1:0] Imm_Ext_E,
  output logic [4:0]      RD_E,
  output logic [4:0]      RS1_E,
  output logic [4:0]      RS2_E,
  output logic [XLEN-1:0] PCE,
  output logic [XLEN-1:0] PCPlus4E
);

  typedef struct packed {
    logic            reg_write;
    logic            alu_src;
    logic            mem_write;
    logic            result_src;
    logic            branch;
    logic [2:0]      alu_control;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
  } idex_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  logic [6:0] op;
  logic [2:0] funct3;
  logic [4:0] rs1, rs2;
  assign op     = InstrD[6:0];
  assign funct3 = InstrD[14:12];
  assign rs1    = InstrD[19:15];
  assign rs2    = InstrD[24:20];

  // ---------------- main decoder ----------------
  logic       reg_write, alu_src, mem_write, result_src, branch;
  logic [1:0] imm_src, alu_op;

  always_comb begin
    reg_write  = 1'b0;
    alu_src    = 1'b0;
    mem_write  = 1'b0;
    result_src = 1'b0;
    branch     = 1'b0;
    imm_src    = 2'b00;
    alu_op     = 2'b00;
    unique case (op)
      OP_LW:   begin reg_write = 1'b1; alu_src = 1'b1; result_src = 1'b1; end
      OP_SW:   begin alu_src = 1'b1; mem_write = 1'b1; imm_src = 2'b01; end
      OP_R:    begin reg_write = 1'b1; alu_op = 2'b10; end
      OP_IALU: begin reg_write = 1'b1; alu_src = 1'b1; alu_op = 2'b10; end
      OP_BEQ:  begin branch = 1'b1; imm_src = 2'b10; alu_op = 2'b01; end
      default: ;  // unknown opcode decodes to a bubble
    endcase
  end

  // ---------------- ALU decoder ----------------
  logic [2:0] alu_control;

  always_comb begin
    alu_control = ALU_ADD;
    unique case (alu_op)
      2'b01: alu_control = ALU_SUB;
      2'b10: begin
        unique case (funct3)
          // op[5] separates R-type sub from addi, which has no sub form
          3'b000:  alu_control = (op[5] && InstrD[30]) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

  // ---------------- immediate extension ----------------
  logic            i31;
  logic [XLEN-1:0] imm_ext;
  assign i31 = InstrD[31];

  always_comb begin
    unique case (imm_src)
      2'b00:   imm_ext = {{(XLEN-12){i31}}, InstrD[31:20]};
      2'b01:   imm_ext = {{(XLEN-12){i31}}, InstrD[31:25], InstrD[11:7]};
      2'b10:   imm_ext = {{(XLEN-12){i31}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
      default: imm_ext = '0;
    endcase
  end

  // ---------------- register file ----------------
  logic [XLEN-1:0] regs_q [REG_COUNT];
  logic [XLEN-1:0] regs_d [REG_COUNT];
  logic            rf_we;
  logic [XLEN-1:0] rd1, rd2;

  assign rf_we = RegWriteW && (RDW != 5'd0);

  always_comb begin
    regs_d = regs_q;
    if (rf_we) regs_d[RDW] = ResultW;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // x0 reads zero even though its storage is never written; a same-cycle
  // writeback to the addressed register is forwarded straight through.
  always_comb begin
    if (rs1 == 5'd0)                 rd1 = '0;
    else if (rf_we && (RDW == rs1)) rd1 = ResultW;
    else                             rd1 = regs_q[rs1];
    if (rs2 == 5'd0)                 rd2 = '0;
    else if (rf_we && (RDW == rs2)) rd2 = ResultW;
    else                             rd2 = regs_q[rs2];
  end

  // ---------------- ID/EX register ----------------
  idex_t idex_d, idex_q;

  always_comb begin
    idex_d.reg_write   = reg_write;
    idex_d.alu_src     = alu_src;
    idex_d.mem_write   = mem_write;
    idex_d.result_src  = result_src;
    idex_d.branch      = branch;
    idex_d.alu_control = alu_control;
    idex_d.rd1         = rd1;
    idex_d.rd2         = rd2;
    idex_d.imm         = imm_ext;
    idex_d.rd          = InstrD[11:7];
    idex_d.rs1         = rs1;
    idex_d.rs2         = rs2;
    idex_d.pc          = PCD;
    idex_d.pc_plus4    = PCPlus4D;
    // a flush only needs to kill controls and register ids; data rides along
    if (FlushE) begin
      idex_d.reg_write   = 1'b0;
      idex_d.alu_src     = 1'b0;
      idex_d.mem_write   = 1'b0;
      idex_d.result_src  = 1'b0;
      idex_d.branch      = 1'b0;
      idex_d.alu_control = 3'b000;
      idex_d.rd          = 5'd0;
      idex_d.rs1         = 5'd0;
      idex_d.rs2         = 5'd0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) idex_q <= '0;
    else      idex_q <= idex_d;
  end

  assign RegWriteE   = idex_q.reg_write;
  assign ALUSrcE     = idex_q.alu_src;
  assign MemWriteE   = idex_q.mem_write;
  assign ResultSrcE  = idex_q.result_src;
  assign BranchE     = idex_q.branch;
  assign ALUControlE = idex_q.alu_control;
  assign RD1_E       = idex_q.rd1;
  assign RD2_E       = idex_q.rd2;
  assign Imm_Ext_E   = idex_q.imm;
  assign RD_E        = idex_q.rd;
  assign RS1_E       = idex_q.rs1;
  assign RS2_E       = idex_q.rs2;
  assign PCE         = idex_q.pc;
  assign PCPlus4E    = idex_q.pc_plus4;

endmodule

// File: doc/decode_cycle.md
Name: decode_cycle

Overview:
Second stage of the 5-stage RV32I pipeline, directly downstream of fetch_cycle. It consumes InstrD, PCD and PCPlus4D, decodes the instruction into control signals, reads the 32x32 register file and sign-extends the immediate. All results are registered into the ID/EX pipeline register for the execute stage. The register file write port is driven from writeback.

Parameters:
XLEN, 32, datapath width
REG_COUNT, 32, architectural registers; x0 hardwired to zero

Ports:
clk  input  1  pipeline clock, rising edge
rst  input  1  asynchronous, active-low reset
InstrD  input  32  instruction from fetch stage
PCD  input  32  PC of InstrD
PCPlus4D  input  32  PCD+4
RegWriteW  input  1  writeback register write enable
RDW  input  5  writeback destination register
ResultW  input  32  writeback data
FlushE  input  1  synchronous bubble insert into ID/EX
RegWriteE  output  1  register write enable
ALUSrcE  output  1  1 = ALU operand B is the immediate
MemWriteE  output  1  store enable
ResultSrcE  output  1  1 = result comes from memory
BranchE  output  1  beq instruction
ALUControlE  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
RD1_E  output  32  rs1 value
RD2_E  output  32  rs2 value
Imm_Ext_E  output  32  sign-extended immediate
RD_E  output  5  InstrD[11:7]
RS1_E  output  5  InstrD[19:15]
RS2_E  output  5  InstrD[24:20]
PCE  output  32  registered PCD
PCPlus4E  output  32  registered PCPlus4D

Behaviour:
- Reset (rst=0, asynchronous): all ID/EX outputs go to 0 and all 32 registers go to 0. Outputs are held while rst=0. The first capture happens on the first rising edge after rst goes high.
- Latency: decode is combinational from InstrD. Outputs appear exactly 1 cycle after InstrD is presented.
- Main decoder, keyed on opcode InstrD[6:0], fields listed as RegWrite/ALUSrc/MemWrite/ResultSrc/Branch/ImmSrc/ALUOp:
  - lw 0000011: 1/1/0/1/0/00/00
  - sw 0100011: 0/1/1/0/0/01/00
  - R-type 0110011: 1/0/0/0/0/xx/10
  - I-ALU 0010011: 1/1/0/0/0/00/10
  - beq 1100011: 0/0/0/0/1/10/01
  - Any other opcode: all controls 0, ImmSrc 00, ALUOp 00. This produces a bubble with no state change.
- ALU decoder:
  - ALUOp 00 -> add.
  - ALUOp 01 -> sub.
  - ALUOp 10 -> decode by funct3 (InstrD[14:12]):
    - 000: sub if {op[5],funct7[5]}=11, else add.
    - 010: slt.
    - 110: or.
    - 111: and.
    - Other funct3 values: add.
- Immediate extension, sign bit InstrD[31]:
  - ImmSrc 00 (I-type): {20{i31}, InstrD[31:20]}.
  - ImmSrc 01 (S-type): {20{i31}, InstrD[31:25], InstrD[11:7]}.
  - ImmSrc 10 (B-type): {19{i31}, i31, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0}.
  - ImmSrc 11: 0.
- Register file:
  - Two combinational read ports (rs1, rs2) and one write port, written on the rising clk edge when RegWriteW=1 and RDW!=0.
  - Writes to x0 are ignored; x0 always reads 0.
  - Write-through bypass: if RegWriteW=1, RDW!=0 and RDW equals the read address, the read returns ResultW in that same cycle. The ID/EX register therefore captures the new value.
- FlushE=1 at a rising edge:
  - All ID/EX control outputs (RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE) load 0.
  - RD_E, RS1_E and RS2_E load 0.
  - Data and PC fields may load normally.
  - The register-file write in the same cycle still occurs.
- Reset asserted mid-operation: outputs clear immediately, without waiting for clk. Any in-flight register write in that cycle is lost.

Test Plan:
1. Hold rst=0 for 2 cycles, then release. All outputs must be 0 while rst=0. Reading x5 after release returns 0.
2. Writeback RegWriteW=1, RDW=5, ResultW=32'h0000_0007. Next cycle, apply InstrD=32'h0062_8233 (add x4,x5,x6). Required: RD1_E=7, RD2_E=0, ALUControlE=000, RegWriteE=1, ALUSrcE=0, RD_E=4.
3. Same-cycle bypass: InstrD=32'hFFC2_A303 (lw x6,-4(x5)) while RegWriteW=1, RDW=5, ResultW=32'h100. Next cycle: RD1_E=32'h100, Imm_Ext_E=32'hFFFF_FFFC, ResultSrcE=1, ALUSrcE=1.
4. InstrD=32'hFE52_0EE3 (beq x4,x5,-4). Required: BranchE=1, ALUControlE=001, Imm_Ext_E=32'hFFFF_FFFC, RegWriteE=0. PCE and PCPlus4E equal the previous PCD and PCPlus4D.
5. Write x0: RegWriteW=1, RDW=0, ResultW=32'hDEAD_BEEF. Any later instruction reading x0 gets 0. Also apply FlushE=1 with an R-type InstrD: all control outputs and RD_E must be 0 in the following cycle.
6. Assert rst=0 between clock edges while a valid sw is in ID/EX. MemWriteE must drop to 0 before the next clk edge.
